// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle LEGv8 datapath: sequences fetch, decode,
// execute, memory and writeback, with a memory-wait timeout and illegal-opcode trap.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] Op,
   input  logic        mem_ready,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        Branch,
   output logic        PCSrc,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        Reg2Loc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        Exc,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWR  = 4'd4,
      S_WBMEM  = 4'd5,
      S_EXEC   = 4'd6,
      S_WBR    = 4'd7,
      S_CBZ    = 4'd8,
      S_ERROR  = 4'd9
   } state_t;

   localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
   localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
   localparam logic [7:0]  CBZ_HI  = 8'b1011_0100;
   localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;

   logic w_is_ldur, w_is_stur, w_is_cbz, w_is_rtype;
   logic w_waiting, w_timeout;

   assign w_is_ldur  = (Op == OP_LDUR);
   assign w_is_stur  = (Op == OP_STUR);
   assign w_is_cbz   = (Op[10:3] == CBZ_HI);
   assign w_is_rtype = (Op == OP_ADD) || (Op == OP_SUB) ||
                       (Op == OP_AND) || (Op == OP_ORR);

   assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                      (r_state == S_MEMWR);
   // A ready in the last allowed cycle still takes the normal path
   assign w_timeout = w_waiting && !mem_ready && (r_wait_cnt == WAIT_LAST);

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next = S_DECODE;
            else if (w_timeout) w_next = S_ERROR;
         end
         S_DECODE: begin
            if (w_is_ldur || w_is_stur) w_next = S_MEMADR;
            else if (w_is_rtype)        w_next = S_EXEC;
            else if (w_is_cbz)          w_next = S_CBZ;
            else                        w_next = S_ERROR;
         end
         S_MEMADR: begin
            if (w_is_ldur)      w_next = S_MEMRD;
            else if (w_is_stur) w_next = S_MEMWR;
            else                w_next = S_ERROR;
         end
         S_MEMRD: begin
            if (mem_ready)      w_next = S_WBMEM;
            else if (w_timeout) w_next = S_ERROR;
         end
         S_MEMWR: begin
            if (mem_ready)      w_next = S_FETCH;
            else if (w_timeout) w_next = S_ERROR;
         end
         S_WBMEM: w_next = S_FETCH;
         S_EXEC:  w_next = S_WBR;
         S_WBR:   w_next = S_FETCH;
         S_CBZ:   w_next = S_FETCH;
         S_ERROR: w_next = S_ERROR;
         default: w_next = S_ERROR;
      endcase
   end

   // State and wait counter; counter restarts on every state change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state)
            r_wait_cnt <= 8'd0;
         else if (w_waiting && !mem_ready)
            r_wait_cnt <= 8'(r_wait_cnt + 8'd1);
      end
   end

   // Moore decode from state; reset forces everything low without a clock edge
   always_comb begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      PCSrc    = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      Exc      = 1'b0;
      if (!reset) begin
         Reg2Loc = (w_is_stur || w_is_cbz) && (r_state != S_ERROR);
         case (r_state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_WBMEM: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_WBR: RegWrite = 1'b1;
            S_CBZ: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b01;
               Branch  = 1'b1;
               PCSrc   = 1'b1;
            end
            S_ERROR: Exc = 1'b1;
            default: Exc = 1'b1;
         endcase
      end
   end

   assign state = reset ? 4'd0 : 4'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: instruction sequences,
// illegal-opcode trap, memory timeout boundary and asynchronous reset.
module tb_multicycle_ctrl;

   logic        clk;
   logic        reset, mem_ready;
   logic [10:0] Op;
   logic        IRWrite, PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite;
   logic        RegWrite, MemtoReg, Reg2Loc, ALUSrcA, Exc;
   logic [1:0]  ALUSrcB, ALUOp;
   logic [3:0]  state;

   logic        reset_b, mem_ready_b;
   logic [10:0] Op_b;
   logic        IRWrite_b, PCWrite_b, Branch_b, PCSrc_b, IorD_b, MemRead_b, MemWrite_b;
   logic        RegWrite_b, MemtoReg_b, Reg2Loc_b, ALUSrcA_b, Exc_b;
   logic [1:0]  ALUSrcB_b, ALUOp_b;
   logic [3:0]  state_b;

   int ntests = 0;
   int nfail  = 0;

   localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [10:0] OP_CBZ  = 11'b101_1010_0010;

   multicycle_ctrl dut_a (
      .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Exc(Exc), .state(state)
   );

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset_b), .Op(Op_b), .mem_ready(mem_ready_b),
      .IRWrite(IRWrite_b), .PCWrite(PCWrite_b), .Branch(Branch_b), .PCSrc(PCSrc_b),
      .IorD(IorD_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b), .RegWrite(RegWrite_b),
      .MemtoReg(MemtoReg_b), .Reg2Loc(Reg2Loc_b), .ALUSrcA(ALUSrcA_b),
      .ALUSrcB(ALUSrcB_b), .ALUOp(ALUOp_b), .Exc(Exc_b), .state(state_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [15:0] w_out = {IRWrite, PCWrite, Branch, PCSrc, IorD, MemRead, MemWrite,
                        RegWrite, MemtoReg, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, Exc};
   wire [15:0] w_out_b = {IRWrite_b, PCWrite_b, Branch_b, PCSrc_b, IorD_b, MemRead_b,
                          MemWrite_b, RegWrite_b, MemtoReg_b, Reg2Loc_b, ALUSrcA_b,
                          ALUSrcB_b, ALUOp_b, Exc_b};

   // Pack hand-specified field values in the same order as w_out
   function automatic logic [15:0] ov(input logic irw, pcw, br, pcs, iord, mr, mw,
                                      rw, m2r, r2l, asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic exc);
      return {irw, pcw, br, pcs, iord, mr, mw, rw, m2r, r2l, asa, asb, aop, exc};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] st, input logic [15:0] o);
      chk({tag, ".state"}, {12'd0, state}, {12'd0, st});
      chk({tag, ".out"}, w_out, o);
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; mem_ready = 1'b1; Op = OP_ADD;
      reset_b = 1'b1; mem_ready_b = 1'b0; Op_b = OP_ADD;
      cyc();
      chk_a("reset", 4'd0, 16'h0000);
      chk("reset_b", w_out_b, 16'h0000);

      // ADD: 0,1,6,7,0
      reset = 1'b0; #1;
      chk_a("add.fetch", 4'd0, ov(1,1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0));
      cyc(); chk_a("add.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0));
      cyc(); chk_a("add.exec",   4'd6, ov(0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0));
      cyc(); chk_a("add.wbr",    4'd7, ov(0,0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,0));
      cyc(); chk_a("add.back",   4'd0, ov(1,1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0));

      // LDUR with three wait cycles in MEMRD: 0,1,2,3,3,3,3,5,0
      Op = OP_LDUR;
      cyc(); chk_a("ld.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0));
      cyc(); chk_a("ld.memadr", 4'd2, ov(0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0));
      mem_ready = 1'b0;
      cyc(); chk_a("ld.memrd0", 4'd3, ov(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,0));
      cyc(); chk_a("ld.memrd1", 4'd3, ov(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,0));
      cyc(); chk_a("ld.memrd2", 4'd3, ov(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,0));
      cyc(); mem_ready = 1'b1; #1;
      chk_a("ld.memrd3", 4'd3, ov(0,0,0,0,1,1,0,0,0,0,0,2'b00,2'b00,0));
      cyc(); chk_a("ld.wbmem", 4'd5, ov(0,0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,0));
      cyc(); chk_a("ld.back",  4'd0, ov(1,1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0));

      // STUR: 0,1,2,4,0 with Reg2Loc throughout
      Op = OP_STUR; #1;
      chk_a("st.fetch", 4'd0, ov(1,1,0,0,0,1,0,0,0,1,0,2'b01,2'b00,0));
      cyc(); chk_a("st.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,1,0,2'b11,2'b00,0));
      cyc(); chk_a("st.memadr", 4'd2, ov(0,0,0,0,0,0,0,0,0,1,1,2'b10,2'b00,0));
      cyc(); chk_a("st.memwr",  4'd4, ov(0,0,0,0,1,0,1,0,0,1,0,2'b00,2'b00,0));
      cyc(); chk_a("st.back",   4'd0, ov(1,1,0,0,0,1,0,0,0,1,0,2'b01,2'b00,0));

      // CBZ: 0,1,8,0
      Op = OP_CBZ;
      cyc(); chk_a("cbz.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,1,0,2'b11,2'b00,0));
      cyc(); chk_a("cbz.cbz",    4'd8, ov(0,0,1,1,0,0,0,0,0,1,1,2'b00,2'b01,0));
      cyc(); chk_a("cbz.back",   4'd0, ov(1,1,0,0,0,1,0,0,0,1,0,2'b01,2'b00,0));

      // Illegal all-ones opcode traps; ERROR absorbs despite mem_ready toggling
      Op = 11'h7FF;
      cyc(); chk_a("ill1.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0));
      cyc(); chk_a("ill1.error",  4'd9, 16'h0001);
      for (int i = 0; i < 20; i++) begin
         mem_ready = ~mem_ready;
         cyc();
         chk_a("ill1.hold", 4'd9, 16'h0001);
      end

      // Reset clears the trap; illegal all-zeros opcode
      reset = 1'b1; #1;
      chk_a("ill.reset", 4'd0, 16'h0000);
      Op = 11'h000; mem_ready = 1'b1;
      cyc(); reset = 1'b0; #1;
      chk_a("ill2.fetch", 4'd0, ov(1,1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0));
      cyc(); chk_a("ill2.decode", 4'd1, ov(0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,0));
      cyc(); chk_a("ill2.error",  4'd9, 16'h0001);

      // Asynchronous reset during a stalled MEMWR
      reset = 1'b1;
      cyc(); reset = 1'b0; Op = OP_STUR; #1;
      cyc(); cyc(); mem_ready = 1'b0;
      cyc(); chk_a("ar.memwr", 4'd4, ov(0,0,0,0,1,0,1,0,0,1,0,2'b00,2'b00,0));
      reset = 1'b1; #1;
      chk_a("ar.during", 4'd0, 16'h0000);
      cyc(); reset = 1'b0; #1;
      chk_a("ar.release", 4'd0, ov(0,0,0,0,0,1,0,0,0,1,0,2'b01,2'b00,0));

      // MEM_TIMEOUT=4: four FETCH cycles without ready, then ERROR
      reset_b = 1'b0; #1;
      chk("to.c0", {12'd0, state_b}, 16'd0);
      cyc(); chk("to.c1", {12'd0, state_b}, 16'd0);
      cyc(); chk("to.c2", {12'd0, state_b}, 16'd0);
      cyc(); chk("to.c3", {12'd0, state_b}, 16'd0);
      cyc(); chk("to.err", {12'd0, state_b}, 16'd9);
      chk("to.err_out", w_out_b, 16'h0001);

      // Ready in the fourth cycle wins over the timeout
      reset_b = 1'b1;
      cyc(); reset_b = 1'b0; #1;
      chk("to2.exc", {15'd0, Exc_b}, 16'd0);
      cyc(); cyc(); cyc(); mem_ready_b = 1'b1; #1;
      chk("to2.c3", w_out_b, ov(1,1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,0));
      cyc(); chk("to2.decode", {12'd0, state_b}, 16'd1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multi-cycle LEGv8 datapath. It sequences the shared ALU, the single unified memory port and the register file across fetch, decode, execute, memory and writeback for LDUR, STUR, CBZ, ADD, SUB, AND and ORR. It replaces the single-cycle main decoder when the datapath is built with a registered IR/ALUOut and a memory that answers with a ready handshake. It also enforces a memory timeout and traps illegal opcodes.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles spent in any memory wait state without mem_ready before trapping; legal range 2..255.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- Op  in  11  instruction bits [31:21] from the IR; valid from DECODE onward, held stable by the IR.
- mem_ready  in  1  memory completed the current read/write this cycle.
- IRWrite  out  1  load IR from memory read data.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load, qualified by the datapath Zero flag.
- PCSrc  out  1  PC source: 0 selects ALU result (PC+4), 1 selects ALUOut (branch target).
- IorD  out  1  memory address: 0 selects PC, 1 selects ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- RegWrite  out  1  register file write enable.
- MemtoReg  out  1  writeback source: 1 selects MDR, 0 selects ALUOut.
- Reg2Loc  out  1  read register 2 source: 1 selects Rt [4:0], 0 selects Rm [20:16].
- ALUSrcA  out  1  ALU A input: 0 selects PC, 1 selects register A.
- ALUSrcB  out  2  ALU B input: 00 selects register B, 01 selects constant 4, 10 selects sign-extended immediate, 11 selects immediate<<2.
- ALUOp  out  2  00 add, 01 pass-B/CBZ, 10 R-type funct decode.
- Exc  out  1  trap flag, sticky until reset.
- state  out  4  current state encoding, for debug.

## Operation
- Opcodes: LDUR 111_1100_0010; STUR 111_1100_0000; CBZ when Op[10:3] = 1011_0100; ADD 100_0101_1000; SUB 110_0101_1000; AND 100_0101_0000; ORR 101_0101_0000. Any other opcode is illegal.
- Reg2Loc = 1 for STUR and CBZ in every state; 0 otherwise.
- Outputs are decoded from state. The only exceptions are IRWrite and PCWrite, which are qualified by mem_ready. Any output not listed for a state is 0.
- States, encoding in brackets:
  - FETCH [0]: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0, IRWrite=PCWrite=mem_ready. Moves to DECODE on mem_ready, else stays.
  - DECODE [1]: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode: LDUR/STUR to MEMADR; R-type to EXEC; CBZ to CBZ; illegal to ERROR.
  - MEMADR [2]: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Moves to MEMRD for LDUR, MEMWR for STUR.
  - MEMRD [3]: MemRead=1, IorD=1. Moves to WBMEM on mem_ready.
  - MEMWR [4]: MemWrite=1, IorD=1. Moves to FETCH on mem_ready.
  - WBMEM [5]: RegWrite=1, MemtoReg=1. Moves to FETCH.
  - EXEC [6]: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Moves to WBR.
  - WBR [7]: RegWrite=1, MemtoReg=0. Moves to FETCH.
  - CBZ [8]: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=1. Moves to FETCH.
  - ERROR [9]: Exc=1, all other outputs 0. Absorbing; left only by reset.
- Wait counter (8-bit):
  - Cleared on entry to FETCH, MEMRD and MEMWR; increments each cycle spent there without mem_ready.
  - If the counter equals MEM_TIMEOUT-1 and mem_ready is low, next state is ERROR.
  - If mem_ready arrives in that same cycle, the normal transition wins.

## Timing
- While reset is high: state=FETCH, counter=0, every output 0 including Exc; state reads 0.
- Reset is asynchronous. It may be asserted mid-instruction, including during MEMWR with MemWrite high, and must kill strobes immediately without waiting for a clock edge.
- First FETCH outputs appear in the first cycle after reset deasserts.
- Cycles per instruction with mem_ready tied high: R-type 4, LDUR 5, STUR 4, CBZ 3. Each memory state adds one cycle per wait cycle.
- Exactly one MemRead pulse per fetch. MemRead and MemWrite are never high in the same cycle.
- Both the IRWrite and PCWrite pulses occur in the final FETCH cycle, the one where mem_ready=1.
- ERROR is entered at the clock edge after an illegal DECODE or after the timeout cycle.

## Test plan
- Reset release, mem_ready=1, Op=100_0101_1000 (ADD): state sequence 0,1,6,7,0. RegWrite=1 only in state 7 with MemtoReg=0. IRWrite and PCWrite each pulse once.
- LDUR 111_1100_0010 with mem_ready low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,5,0. MemRead and IorD stay high throughout MEMRD. RegWrite with MemtoReg=1 in state 5.
- STUR, then CBZ 101_1010_0010, mem_ready=1:
  - STUR: 0,1,2,4,0, with MemWrite=1 only in state 4. Reg2Loc=1 throughout.
  - CBZ: 0,1,8,0, with Branch=1, PCSrc=1, ALUOp=01 in state 8.
- Illegal opcodes 111_1111_1111 and 000_0000_0000 at DECODE: next state 9, Exc=1, all strobes 0. State remains 9 for 20 cycles despite toggling mem_ready.
- MEM_TIMEOUT=4, mem_ready held low in FETCH: 4 cycles in state 0, then 9. A second run with mem_ready rising in the 4th cycle must reach DECODE, not ERROR.
- Assert reset asynchronously mid-cycle during MEMWR: MemWrite falls before the next clk edge. After release, state=0 and Exc=0.
